// File: rtl/vga_pkg.sv
// Shared VGA-side types: lever display state plus small elaboration helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    LEVER_NEUTRAL = 2'd0,
    LEVER_UP      = 2'd1,
    LEVER_DOWN    = 2'd2
  } lever_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Zero-length timers behave as one frame.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-flop synchronizer followed by a rising-edge pulse.
// RST_VAL lets a level that is already high at reset look "old", so it cannot fire.
module edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/lever_ctl.sv
// Lever control: hover test, click capture, hold/cooldown timing and a
// frame-latched display state for draw_lever.
module lever_ctl
  import vga_pkg::*;
#(
  parameter int lever_posit_x   = 100,
  parameter int lever_posit_y   = 100,
  parameter int width           = 100,
  parameter int height          = 50,
  parameter int highlight_range = 3,
  parameter int hold_frames     = 30,
  parameter int cooldown_frames = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vblnk,
  input  logic [11:0]  xpos,
  input  logic [11:0]  ypos,
  input  logic         mouse_left,
  output lever_state_t lever_state,
  output logic         highlight,
  output logic         pull_event,
  output logic         pull_dir
);

  typedef enum logic [1:0] {IDLE, PULLED, COOLDOWN} lever_fsm_t;

  localparam int HOLD_EFF = at_least_one(hold_frames);
  localparam int COOL_EFF = at_least_one(cooldown_frames);
  localparam int CW       = $clog2(max_int(HOLD_EFF, COOL_EFF) + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_EFF - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOL_EFF - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  // Signed 13-bit bounds so a box near the origin does not wrap negative.
  localparam logic signed [12:0] X_LO  = 13'(lever_posit_x - highlight_range);
  localparam logic signed [12:0] X_HI  = 13'(lever_posit_x + width + highlight_range);
  localparam logic signed [12:0] Y_LO  = 13'(lever_posit_y - highlight_range);
  localparam logic signed [12:0] Y_HI  = 13'(lever_posit_y + height + highlight_range);
  localparam logic signed [12:0] Y_MID = 13'(lever_posit_y + height / 2);

  logic [11:0] xpos_q, ypos_q;
  logic        click, tick;

  lever_fsm_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pe_q, pe_d;
  logic          dir_q, dir_d;
  lever_state_t  lever_q, lever_d;
  logic          hl_q, hl_d;

  logic signed [12:0] x_s, y_s;
  logic               hit, upper;

  // Mouse button resets high so a press held through reset is not a click.
  edge_detect #(.RST_VAL(1'b1)) u_click (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mouse_left),
    .rise_o (click)
  );

  edge_detect #(.RST_VAL(1'b0)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .d_i    (vblnk),
    .rise_o (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q <= '0;
      ypos_q <= '0;
    end else begin
      xpos_q <= xpos;
      ypos_q <= ypos;
    end
  end

  assign x_s   = signed'({1'b0, xpos_q});
  assign y_s   = signed'({1'b0, ypos_q});
  assign hit   = (x_s >= X_LO) && (x_s <= X_HI) && (y_s >= Y_LO) && (y_s <= Y_HI);
  assign upper = (y_s < Y_MID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pe_q    <= 1'b0;
      dir_q   <= 1'b0;
      lever_q <= LEVER_NEUTRAL;
      hl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pe_q    <= pe_d;
      dir_q   <= dir_d;
      lever_q <= lever_d;
      hl_q    <= hl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pe_d    = 1'b0;
    dir_d   = dir_q;
    lever_d = lever_q;
    hl_d    = hl_q;

    // A click coinciding with a tick in IDLE wins; that tick is not counted.
    unique case (state_q)
      IDLE: begin
        if (click && hit) begin
          state_d = PULLED;
          cnt_d   = '0;
          pe_d    = 1'b1;
          dir_d   = upper;
        end
      end
      PULLED: begin
        if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = COOLDOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
          end
        end
      end
      COOLDOWN: begin
        if (tick) begin
          if (cnt_q == COOL_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Display reflects the state being entered at this frame boundary.
    if (tick) begin
      if (state_d == PULLED) lever_d = dir_d ? LEVER_UP : LEVER_DOWN;
      else                   lever_d = LEVER_NEUTRAL;
      hl_d = hit && (state_d == IDLE);
    end
  end

  assign lever_state = lever_q;
  assign highlight   = hl_q;
  assign pull_event  = pe_q;
  assign pull_dir    = dir_q;

endmodule

// File: tb/tb_lever_ctl.sv
// Directed bench for lever_ctl: hover, pulls, timing windows, edges and reset.
module tb_lever_ctl;
  import vga_pkg::*;

  logic         clk = 1'b0;
  logic         rst, vblnk, mouse_left;
  logic [11:0]  xpos, ypos;
  lever_state_t lever_state;
  logic         highlight, pull_event, pull_dir;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  lever_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (vblnk),
    .xpos        (xpos),
    .ypos        (ypos),
    .mouse_left  (mouse_left),
    .lever_state (lever_state),
    .highlight   (highlight),
    .pull_event  (pull_event),
    .pull_dir    (pull_dir)
  );

  task automatic apply_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
  endtask

  // One frame: vblnk rise, then enough cycles for the latch to settle.
  task automatic frame();
    @(negedge clk) vblnk = 1'b1;
    repeat (3) @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Press; pull_event must pulse exactly on the third cycle when accepted.
  task automatic click(input logic exp_ev, input logic hold, input string nm);
    logic e;
    @(negedge clk) mouse_left = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = exp_ev && (k == 3);
      vectors++;
      if (pull_event !== e) begin
        errors++;
        $display("FAIL %s pull_event cyc%0d got %b exp %b", nm, k, pull_event, e);
      end
    end
    if (!hold) begin
      mouse_left = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vblnk = 1'b0; mouse_left = 1'b0; set_pos(0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (lever_state !== LEVER_NEUTRAL || highlight !== 1'b0 || pull_event !== 1'b0 || pull_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset got state=%0d hl=%b pe=%b pd=%b exp 0/0/0/0",
               lever_state, highlight, pull_event, pull_dir);
    end
  endtask

  task automatic test_pull_up();
    apply_reset();
    set_pos(150, 110);
    click(1'b1, 1'b0, "up_click");
    vectors++;
    if (pull_dir !== 1'b1) begin errors++; $display("FAIL up_dir got %b exp 1", pull_dir); end
    vectors++;
    if (lever_state !== LEVER_NEUTRAL) begin
      errors++; $display("FAIL up_pre_tick state got %0d exp %0d", lever_state, LEVER_NEUTRAL);
    end
    frame();
    vectors++;
    if (lever_state !== LEVER_UP || highlight !== 1'b0) begin
      errors++; $display("FAIL up_shown state=%0d hl=%b exp %0d/0", lever_state, highlight, LEVER_UP);
    end
  endtask

  task automatic test_pull_down_timing();
    apply_reset();
    set_pos(150, 140);
    frame();
    vectors++;
    if (highlight !== 1'b1) begin errors++; $display("FAIL hover hl got %b exp 1", highlight); end
    click(1'b1, 1'b0, "down_click");
    vectors++;
    if (pull_dir !== 1'b0) begin errors++; $display("FAIL down_dir got %b exp 0", pull_dir); end
    frames(29);
    vectors++;
    if (lever_state !== LEVER_DOWN) begin
      errors++; $display("FAIL hold29 state got %0d exp %0d", lever_state, LEVER_DOWN);
    end
    frame();
    vectors++;
    if (lever_state !== LEVER_NEUTRAL) begin
      errors++; $display("FAIL hold30 state got %0d exp %0d", lever_state, LEVER_NEUTRAL);
    end
    frames(14);
    click(1'b0, 1'b0, "cool14_click");
    frame();
    click(1'b1, 1'b0, "cool15_click");
  endtask

  task automatic test_hit_edges();
    int   px[4] = '{97, 203, 96, 100};
    int   py[4] = '{97, 153, 100, 154};
    logic ex[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      set_pos(px[i], py[i]);
      frame();
      vectors++;
      if (highlight !== ex[i]) begin
        errors++; $display("FAIL edge%0d hl got %b exp %b", i, highlight, ex[i]);
      end
      click(ex[i], 1'b0, $sformatf("edge%0d_click", i));
    end
  endtask

  task automatic test_busy_clicks();
    apply_reset();
    set_pos(150, 110);
    click(1'b1, 1'b0, "busy_first");
    click(1'b0, 1'b0, "busy_pulled");
    frame();
    click(1'b0, 1'b0, "busy_pulled2");
    vectors++;
    if (lever_state !== LEVER_UP) begin
      errors++; $display("FAIL busy_pulled state got %0d exp %0d", lever_state, LEVER_UP);
    end
    frames(29);
    click(1'b0, 1'b0, "busy_cool");
    frame();
    vectors++;
    if (lever_state !== LEVER_NEUTRAL) begin
      errors++; $display("FAIL busy_cool state got %0d exp %0d", lever_state, LEVER_NEUTRAL);
    end
  endtask

  task automatic test_click_tick_same_cycle();
    logic e;
    apply_reset();
    set_pos(150, 110);
    @(negedge clk);
    mouse_left = 1'b1;
    vblnk      = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = (k == 3);
      vectors++;
      if (pull_event !== e) begin
        errors++; $display("FAIL coinc pull_event cyc%0d got %b exp %b", k, pull_event, e);
      end
    end
    mouse_left = 1'b0;
    vblnk      = 1'b0;
    repeat (4) @(negedge clk);
    frames(29);
    vectors++;
    if (lever_state !== LEVER_UP) begin
      errors++; $display("FAIL coinc29 state got %0d exp %0d", lever_state, LEVER_UP);
    end
    frame();
    vectors++;
    if (lever_state !== LEVER_NEUTRAL) begin
      errors++; $display("FAIL coinc30 state got %0d exp %0d", lever_state, LEVER_NEUTRAL);
    end
  endtask

  task automatic test_reset_mid_pull();
    apply_reset();
    set_pos(150, 110);
    click(1'b1, 1'b1, "rst_first");
    frame();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (lever_state !== LEVER_NEUTRAL || highlight !== 1'b0 || pull_event !== 1'b0 || pull_dir !== 1'b0) begin
      errors++;
      $display("FAIL midrst got state=%0d hl=%b pe=%b pd=%b exp 0/0/0/0",
               lever_state, highlight, pull_event, pull_dir);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (pull_event !== 1'b0) begin
        errors++; $display("FAIL held_btn cyc%0d pull_event got %b exp 0", k, pull_event);
      end
    end
    mouse_left = 1'b0;
    repeat (4) @(negedge clk);
    click(1'b1, 1'b0, "repress");
  endtask

  initial begin
    test_reset();
    test_pull_up();
    test_pull_down_timing();
    test_hit_edges();
    test_busy_clicks();
    test_click_tick_same_cycle();
    test_reset_mid_pull();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
